// File: rtl/nrisc_pkg.sv
// Shared nRisc definitions: instruction word geometry and the fetch-stage state
// enumeration used by the fetch unit, the core top and the bench.
package nrisc_pkg;

  localparam int INSTR_W = 8;
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 5;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    BUSCA  = 2'd1,
    ESPERA = 2'd2,
    PARADO = 2'd3
  } estado_busca_t;

endpackage

// File: rtl/busca_instrucao_contador_pc.sv
// Program counter for the fetch stage: async reset to RESET_PC, target load
// takes priority over sequential increment (modulo 2^PC_W).
module contador_pc #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            carrega,
  input  logic            incrementa,
  input  logic [PC_W-1:0] alvo,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] UM = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] pc_r;

  // PC register: load target, step, or hold
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_r <= RESET_PC;
    end else if (carrega) begin
      pc_r <= alvo;
    end else if (incrementa) begin
      pc_r <= pc_r + UM;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/busca_instrucao.sv
// nRisc instruction fetch: memory request/ack handshake, holds the fetched word
// until the core accepts it, then steps or branches the PC; Encerra halts for good.
module busca_instrucao
  import nrisc_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               desvio,
  input  logic [PC_W-1:0]    alvo,
  input  logic               encerra,
  output logic [PC_W-1:0]    pc,
  output logic               parado
);

  estado_busca_t      state_r;
  estado_busca_t      state_next_s;
  logic [INSTR_W-1:0] instr_r;
  logic               captura_s;
  logic               carrega_s;
  logic               incrementa_s;

  contador_pc #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_contador_pc (
    .clock      (clock),
    .reset_n    (reset_n),
    .carrega    (carrega_s),
    .incrementa (incrementa_s),
    .alvo       (alvo),
    .pc         (pc)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= OCIOSO;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and PC/instruction enables; acceptance priority is encerra > desvio > step
  always_comb begin
    state_next_s = state_r;
    captura_s    = 1'b0;
    carrega_s    = 1'b0;
    incrementa_s = 1'b0;
    case (state_r)
      OCIOSO: state_next_s = BUSCA;
      BUSCA: begin
        if (mem_ack) begin
          captura_s    = 1'b1;
          state_next_s = ESPERA;
        end else begin
          state_next_s = BUSCA;
        end
      end
      ESPERA: begin
        if (!instr_ready) begin
          state_next_s = ESPERA;
        end else if (encerra) begin
          state_next_s = PARADO;
        end else if (desvio) begin
          carrega_s    = 1'b1;
          state_next_s = BUSCA;
        end else begin
          incrementa_s = 1'b1;
          state_next_s = BUSCA;
        end
      end
      PARADO:  state_next_s = PARADO;
      default: state_next_s = OCIOSO;
    endcase
  end

  // Held instruction register, written only on the edge that leaves BUSCA
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_r <= {INSTR_W{1'b0}};
    end else if (captura_s) begin
      instr_r <= mem_rdata;
    end else begin
      instr_r <= instr_r;
    end
  end

  // Moore outputs straight from the state register, so reset drops mem_req at once
  assign mem_req     = (state_r == BUSCA);
  assign instr_valid = (state_r == ESPERA);
  assign parado      = (state_r == PARADO);
  assign mem_addr    = pc;
  assign instr       = instr_r;

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: sequential fetch, memory/core stalls,
// branch, halt, PC wrap and reset abandoning an outstanding request.
module tb_busca_instrucao;
  import nrisc_pkg::*;

  localparam int PC_W = 8;

  logic            clock;
  logic            reset_n;
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ack;
  logic [7:0]      mem_rdata;
  logic [7:0]      instr;
  logic            instr_valid;
  logic            instr_ready;
  logic            desvio;
  logic [PC_W-1:0] alvo;
  logic            encerra;
  logic [PC_W-1:0] pc;
  logic            parado;

  int n_checks = 0;
  int n_errors = 0;

  busca_instrucao #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .desvio      (desvio),
    .alvo        (alvo),
    .encerra     (encerra),
    .pc          (pc),
    .parado      (parado)
  );

  // Memory image: every address holds a distinct, nonzero-at-0 word
  function automatic logic [7:0] img(input logic [7:0] a);
    return (a * 8'd37) + 8'd11;
  endfunction

  assign mem_rdata = img(mem_addr);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
    desvio = 1'b0; encerra = 1'b0; alvo = 8'h00;
    #12;
    check("rst_req",    32'(mem_req), 32'd0);
    check("rst_valid",  32'(instr_valid), 32'd0);
    check("rst_instr",  32'(instr), 32'h00);
    check("rst_parado", 32'(parado), 32'd0);
    check("rst_pc",     32'(pc), 32'h00);

    // Sequential fetch, zero-wait memory, core always ready
    @(negedge clock); reset_n = 1'b1; mem_ack = 1'b1; instr_ready = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      check("seq_req",   32'(mem_req), 32'd1);
      check("seq_addr",  32'(mem_addr), 32'(k));
      check("seq_nval",  32'(instr_valid), 32'd0);
      @(negedge clock);
      check("seq_valid", 32'(instr_valid), 32'd1);
      check("seq_instr", 32'(instr), 32'(img(8'(k))));
      check("seq_noreq", 32'(mem_req), 32'd0);
      @(negedge clock);
    end

    // Memory waits three cycles, then core stalls four cycles
    mem_ack = 1'b0; instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("wait_req",  32'(mem_req), 32'd1);
      check("wait_addr", 32'(mem_addr), 32'h04);
      check("wait_nval", 32'(instr_valid), 32'd0);
      @(negedge clock);
    end
    mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    check("wait_cap", 32'(instr), 32'(img(8'h04)));
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_instr", 32'(instr), 32'(img(8'h04)));
      check("stall_pc",    32'(pc), 32'h04);
    end

    // Branch to 0x40
    instr_ready = 1'b1; desvio = 1'b1; alvo = 8'h40;
    @(negedge clock);
    check("br_addr", 32'(mem_addr), 32'h40);
    check("br_req",  32'(mem_req), 32'd1);
    instr_ready = 1'b0; desvio = 1'b0; mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    check("br_instr", 32'(instr), 32'(img(8'h40)));

    // Encerra beats desvio
    instr_ready = 1'b1; desvio = 1'b1; encerra = 1'b1; alvo = 8'h10;
    @(negedge clock);
    check("halt_parado", 32'(parado), 32'd1);
    check("halt_valid",  32'(instr_valid), 32'd0);
    check("halt_req",    32'(mem_req), 32'd0);
    check("halt_pc",     32'(pc), 32'h40);

    // Toggle everything while halted
    for (int k = 0; k < 4; k++) begin
      mem_ack = k[0]; instr_ready = ~k[0]; desvio = k[1]; encerra = k[0];
      @(negedge clock);
      check("park_parado", 32'(parado), 32'd1);
      check("park_req",    32'(mem_req), 32'd0);
      check("park_valid",  32'(instr_valid), 32'd0);
      check("park_pc",     32'(pc), 32'h40);
      check("park_instr",  32'(instr), 32'(img(8'h40)));
    end

    // Reset mid-BUSCA with an ack landing during reset
    mem_ack = 1'b0; instr_ready = 1'b0; desvio = 1'b0; encerra = 1'b0;
    reset_n = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    check("rb_req", 32'(mem_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rb_async_req", 32'(mem_req), 32'd0);
    check("rb_pc",        32'(pc), 32'h00);
    mem_ack = 1'b1;
    @(negedge clock);
    check("rb_late_instr", 32'(instr), 32'h00);
    check("rb_late_valid", 32'(instr_valid), 32'd0);
    mem_ack = 1'b0; reset_n = 1'b1;
    @(negedge clock);
    check("rb_restart_addr", 32'(mem_addr), 32'h00);
    check("rb_restart_req",  32'(mem_req), 32'd1);
    check("rb_restart_nval", 32'(instr_valid), 32'd0);
    mem_ack = 1'b1;
    @(negedge clock);
    check("rb_instr", 32'(instr), 32'(img(8'h00)));

    // Jump to 0xFF then step: address wraps to 0x00
    instr_ready = 1'b1; desvio = 1'b1; alvo = 8'hFF;
    @(negedge clock);
    check("wrap_ff", 32'(mem_addr), 32'hFF);
    desvio = 1'b0;
    @(negedge clock);
    check("wrap_instr", 32'(instr), 32'(img(8'hFF)));
    @(negedge clock);
    check("wrap_00",  32'(mem_addr), 32'h00);
    check("wrap_req", 32'(mem_req), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
